// File: rtl/bingo_pkg.sv
// Shared definitions for the bingo round controller.
//   state_t            : controller state encoding
//   DELETED_VALUE      : card value that marks a deleted (already matched) cell
//   DEFAULT_TICK_COUNT : blink half-period in clock cycles (1 s at 50 MHz)
package bingo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DRAW,
    ST_LOAD,
    ST_READ,
    ST_CMP,
    ST_MARK,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int DELETED_VALUE      = 0;
  localparam int DEFAULT_TICK_COUNT = 50_000_000;

endpackage

// File: rtl/bingo_round_ctrl_if.sv
// Card RAM bus between the round controller and the shared card RAM.
//   ram_addr        : cell address (controller -> RAM)
//   ram_write_en    : write strobe; the written value is always the deleted value
//   ram_delete      : same as ram_write_en, for RAMs that take a delete strobe
//   ram_read_number : read data, valid one cycle after ram_addr (RAM -> controller)
interface bingo_round_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_write_en;
  logic                  ram_delete;
  logic [DATA_WIDTH-1:0] ram_read_number;

  modport master (
    output ram_addr,
    output ram_write_en,
    output ram_delete,
    input  ram_read_number
  );

  modport slave (
    input  ram_addr,
    input  ram_write_en,
    input  ram_delete,
    output ram_read_number
  );

endinterface

// File: rtl/counter.sv
// Generic up-counter, 0..MAX-1 with wrap.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : synchronous clear, wins over en
//   en        : count enable
//   count     : current count
module counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/bingo_round_ctrl.sv
// Bingo round controller: per draw, latches the number, scans every card cell,
// deletes and marks each match, then reports all players with a complete card.
//   clk, rstn        : clock, synchronous active-low reset
//   start_game       : leave IDLE
//   abort            : return to IDLE from any state, suppressing any RAM write
//   next_edge        : one-cycle draw pulse, honoured only in WAIT_DRAW
//   guessed_number   : drawn number, sampled in LOAD
//   ram              : card RAM bus (master side)
//   game_state       : marked-cell bitmap
//   winners          : complete-card flags, valid while endgame
//   guessed_number_r : latched draw
//   enable_displays  : high while reading/comparing cells
//   draw_ignored     : pulse when a draw of 0 is rejected
//   busy             : high from LOAD through CHECK
//   toggle_1s        : blink output, toggles every TICK_COUNT cycles in WAIT_DRAW
//   endgame          : high in DONE
module bingo_round_ctrl
  import bingo_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_PLAYERS      = 2,
  parameter int CELLS_PER_PLAYER = 8,
  parameter int NUM_CELLS        = NUM_PLAYERS * CELLS_PER_PLAYER,
  parameter int ADDR_WIDTH       = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1,
  parameter int TICK_COUNT       = DEFAULT_TICK_COUNT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_game,
  input  logic                    abort,
  input  logic                    next_edge,
  input  logic [DATA_WIDTH-1:0]   guessed_number,
  bingo_round_ctrl_if.master      ram,
  output logic [NUM_CELLS-1:0]    game_state,
  output logic [NUM_PLAYERS-1:0]  winners,
  output logic [DATA_WIDTH-1:0]   guessed_number_r,
  output logic                    enable_displays,
  output logic                    draw_ignored,
  output logic                    busy,
  output logic                    toggle_1s,
  output logic                    endgame
);

  localparam int TICK_WIDTH = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   guessed_q, guessed_d;
  logic [NUM_CELLS-1:0]    game_state_q, game_state_d;
  logic [NUM_PLAYERS-1:0]  winners_q, winners_d;
  logic                    toggle_q, toggle_d;

  logic [ADDR_WIDTH-1:0]   addr;
  logic [TICK_WIDTH-1:0]   tick_cnt;
  logic                    addr_clr, addr_en, tick_en, tick_wrap;
  logic                    last_cell, match, draw_is_zero, write_en;
  logic [NUM_PLAYERS-1:0]  card_full;

  // Explicit compare against the last index so non-power-of-2 depths stop in range.
  assign last_cell    = (addr == ADDR_WIDTH'(NUM_CELLS - 1));
  assign match        = (ram.ram_read_number == guessed_q);
  assign draw_is_zero = (guessed_number == DATA_WIDTH'(DELETED_VALUE));
  assign tick_wrap    = (tick_cnt == TICK_WIDTH'(TICK_COUNT - 1));

  always_comb begin
    card_full = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      card_full[p] = &game_state_q[p*CELLS_PER_PLAYER +: CELLS_PER_PLAYER];
    end
  end

  counter #(.WIDTH(ADDR_WIDTH), .MAX(NUM_CELLS)) u_addr_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (addr_clr),
    .en    (addr_en),
    .count (addr)
  );

  // Never cleared outside reset: the blink phase resumes after each scan.
  counter #(.WIDTH(TICK_WIDTH), .MAX(TICK_COUNT)) u_blink_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (1'b0),
    .en    (tick_en),
    .count (tick_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start_game) state_d = ST_WAIT_DRAW;
        ST_WAIT_DRAW: if (next_edge)  state_d = ST_LOAD;
        ST_LOAD:      state_d = draw_is_zero ? ST_WAIT_DRAW : ST_READ;
        ST_READ:      state_d = ST_CMP;
        ST_CMP: begin
          if (match)          state_d = ST_MARK;
          else if (last_cell) state_d = ST_CHECK;
          else                state_d = ST_READ;
        end
        ST_MARK:      state_d = last_cell ? ST_CHECK : ST_READ;
        ST_CHECK:     state_d = (|card_full) ? ST_DONE : ST_WAIT_DRAW;
        ST_DONE:      state_d = ST_DONE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    write_en        = (state_q == ST_MARK) && !abort;
    enable_displays = (state_q == ST_READ) || (state_q == ST_CMP);
    busy            = (state_q == ST_LOAD) || (state_q == ST_READ) || (state_q == ST_CMP) ||
                      (state_q == ST_MARK) || (state_q == ST_CHECK);
    endgame         = (state_q == ST_DONE);
    draw_ignored    = (state_q == ST_LOAD) && draw_is_zero;
    addr_clr        = (state_q == ST_IDLE) || (state_q == ST_WAIT_DRAW);
    addr_en         = !abort && !last_cell &&
                      (((state_q == ST_CMP) && !match) || (state_q == ST_MARK));
    tick_en         = (state_q == ST_WAIT_DRAW);
  end

  always_comb begin
    guessed_d    = guessed_q;
    game_state_d = game_state_q;
    winners_d    = winners_q;
    toggle_d     = toggle_q ^ (tick_en && tick_wrap);
    if (state_q == ST_LOAD) guessed_d = guessed_number;
    if (abort || (state_q == ST_IDLE)) begin
      game_state_d = '0;
      winners_d    = '0;
    end else if (state_q == ST_MARK) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (addr == ADDR_WIDTH'(i)) game_state_d[i] = 1'b1;
      end
    end else if (state_q == ST_CHECK) begin
      winners_d = card_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      guessed_q    <= '0;
      game_state_q <= '0;
      winners_q    <= '0;
      toggle_q     <= 1'b0;
    end else begin
      guessed_q    <= guessed_d;
      game_state_q <= game_state_d;
      winners_q    <= winners_d;
      toggle_q     <= toggle_d;
    end
  end

  assign ram.ram_addr     = addr;
  assign ram.ram_write_en = write_en;
  assign ram.ram_delete   = write_en;

  assign game_state       = game_state_q;
  assign winners          = winners_q;
  assign guessed_number_r = guessed_q;
  assign toggle_1s        = toggle_q;

endmodule

// File: tb/tb_bingo_round_ctrl.sv
// Directed bench for bingo_round_ctrl: 2 players x 8 cells, TICK_COUNT = 4,
// with a registered card RAM model that zeroes a cell on each write strobe.
module tb_bingo_round_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_game;
  logic        abort;
  logic        next_edge;
  logic [7:0]  guessed_number;
  logic [15:0] game_state;
  logic [1:0]  winners;
  logic [7:0]  guessed_number_r;
  logic        enable_displays;
  logic        draw_ignored;
  logic        busy;
  logic        toggle_1s;
  logic        endgame;

  int checks = 0;
  int errors = 0;

  bingo_round_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ram_if ();

  bingo_round_ctrl #(.TICK_COUNT(4)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .start_game       (start_game),
    .abort            (abort),
    .next_edge        (next_edge),
    .guessed_number   (guessed_number),
    .ram              (ram_if),
    .game_state       (game_state),
    .winners          (winners),
    .guessed_number_r (guessed_number_r),
    .enable_displays  (enable_displays),
    .draw_ignored     (draw_ignored),
    .busy             (busy),
    .toggle_1s        (toggle_1s),
    .endgame          (endgame)
  );

  always #5 clk = ~clk;

  // Card RAM model
  logic [7:0] mem [16];
  logic [7:0] init_img [16];
  logic       load_img = 1'b0;

  always @(posedge clk) begin
    ram_if.ram_read_number <= mem[ram_if.ram_addr];
    if (load_img) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
    end else if (ram_if.ram_write_en) begin
      mem[ram_if.ram_addr] <= 8'd0;
    end
  end

  // Per-draw observations
  int         busy_cnt, wr_cnt, en_cnt;
  logic       ign_seen;
  logic [3:0] wr_addr [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; start_game = 1'b0; abort = 1'b0; next_edge = 1'b0; guessed_number = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) init_img[i] = 8'(i + 1);
  endtask

  task automatic load_card();
    load_img = 1'b1;
    step();
    load_img = 1'b0;
  endtask

  task automatic start();
    start_game = 1'b1;
    step();
    start_game = 1'b0;
  endtask

  // Pulses next_edge and follows the scan until busy drops.
  task automatic run_draw(input logic [7:0] num);
    int guard;
    guessed_number = num;
    next_edge = 1'b1;
    step();
    next_edge = 1'b0;
    busy_cnt = 0; wr_cnt = 0; en_cnt = 0; ign_seen = 1'b0; guard = 0;
    while (busy && guard < 200) begin
      busy_cnt++;
      if (enable_displays) en_cnt++;
      if (draw_ignored) ign_seen = 1'b1;
      if (ram_if.ram_write_en) begin
        if (wr_cnt < 4) wr_addr[wr_cnt] = ram_if.ram_addr;
        wr_cnt++;
      end
      step();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL draw_timeout: busy still %0d after %0d cycles, required 0", busy, guard);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (game_state !== 16'h0) begin errors++; $display("FAIL rst_game_state: got %h expected 0000", game_state); end
    checks++; if (winners !== 2'b00) begin errors++; $display("FAIL rst_winners: got %b expected 00", winners); end
    checks++; if (guessed_number_r !== 8'd0) begin errors++; $display("FAIL rst_guess: got %0d expected 0", guessed_number_r); end
    checks++; if (ram_if.ram_addr !== 4'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", ram_if.ram_addr); end
    checks++; if ({busy, endgame, toggle_1s, draw_ignored, ram_if.ram_write_en, enable_displays} !== 6'b0)
      begin errors++; $display("FAIL rst_strobes: got %b expected 000000",
        {busy, endgame, toggle_1s, draw_ignored, ram_if.ram_write_en, enable_displays}); end
  endtask

  task automatic test_reset_mid_scan();
    do_reset(); fill_seq(); load_card(); start();
    run_draw(8'd3);
    guessed_number = 8'd10;
    next_edge = 1'b1; step(); next_edge = 1'b0;   // LOAD
    step();                                       // READ
    step();                                       // CMP
    checks++; if (!(enable_displays === 1'b1 && busy === 1'b1))
      begin errors++; $display("FAIL mid_in_cmp: enable %b busy %b expected 1 1", enable_displays, busy); end
    rstn = 1'b0;
    #1;
    checks++; if (ram_if.ram_write_en !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %b expected 0", ram_if.ram_write_en); end
    step();
    rstn = 1'b1;
    checks++; if (game_state !== 16'h0) begin errors++; $display("FAIL mid_game_state: got %h expected 0000", game_state); end
    checks++; if (busy !== 1'b0 || ram_if.ram_addr !== 4'd0) begin errors++; $display("FAIL mid_idle: busy %b addr %0d expected 0 0", busy, ram_if.ram_addr); end
    next_edge = 1'b1; step(); next_edge = 1'b0; step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_ignores_draw: busy %b expected 0", busy); end
  endtask

  task automatic test_single_match();
    do_reset(); fill_seq(); load_card(); start();
    run_draw(8'd5);
    checks++; if (busy_cnt != 35) begin errors++; $display("FAIL single_latency: got %0d expected 35", busy_cnt); end
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL single_writes: got %0d expected 1", wr_cnt); end
    checks++; if (wr_addr[0] !== 4'd4) begin errors++; $display("FAIL single_addr: got %0d expected 4", wr_addr[0]); end
    checks++; if (game_state !== 16'h0010) begin errors++; $display("FAIL single_game_state: got %h expected 0010", game_state); end
    checks++; if (en_cnt != 32) begin errors++; $display("FAIL single_display_cycles: got %0d expected 32", en_cnt); end
    checks++; if (guessed_number_r !== 8'd5) begin errors++; $display("FAIL single_latched: got %0d expected 5", guessed_number_r); end
    checks++; if (mem[4] !== 8'd0) begin errors++; $display("FAIL single_deleted: got %0d expected 0", mem[4]); end
    checks++; if (endgame !== 1'b0 || winners !== 2'b00) begin errors++; $display("FAIL single_no_win: endgame %b winners %b expected 0 00", endgame, winners); end
  endtask

  task automatic test_duplicate();
    do_reset(); fill_seq();
    init_img[3] = 8'd7; init_img[6] = 8'd4; init_img[11] = 8'd7;
    load_card(); start();
    run_draw(8'd7);
    checks++; if (busy_cnt != 36) begin errors++; $display("FAIL dup_latency: got %0d expected 36", busy_cnt); end
    checks++; if (wr_cnt != 2) begin errors++; $display("FAIL dup_writes: got %0d expected 2", wr_cnt); end
    checks++; if (wr_addr[0] !== 4'd3 || wr_addr[1] !== 4'd11)
      begin errors++; $display("FAIL dup_addrs: got %0d,%0d expected 3,11", wr_addr[0], wr_addr[1]); end
    checks++; if (game_state !== 16'h0808) begin errors++; $display("FAIL dup_game_state: got %h expected 0808", game_state); end
  endtask

  task automatic test_zero_draw_and_blink();
    logic prev;
    int   n;
    run_draw(8'd0);
    checks++; if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy: got %0d expected 1", busy_cnt); end
    checks++; if (ign_seen !== 1'b1) begin errors++; $display("FAIL zero_ignored_pulse: got %b expected 1", ign_seen); end
    checks++; if (wr_cnt != 0 || en_cnt != 0) begin errors++; $display("FAIL zero_no_ram: writes %0d reads %0d expected 0 0", wr_cnt, en_cnt); end
    checks++; if (game_state !== 16'h0808) begin errors++; $display("FAIL zero_game_state: got %h expected 0808", game_state); end
    checks++; if (draw_ignored !== 1'b0) begin errors++; $display("FAIL zero_pulse_width: got %b expected 0", draw_ignored); end
    prev = toggle_1s; n = 0;
    while (toggle_1s === prev && n < 8) begin step(); n++; end
    checks++; if (n >= 8) begin errors++; $display("FAIL blink_first_edge: no toggle in %0d cycles, required at most 4", n); end
    for (int k = 0; k < 2; k++) begin
      prev = toggle_1s; n = 0;
      do begin step(); n++; end while (toggle_1s === prev && n < 10);
      checks++; if (n != 4) begin errors++; $display("FAIL blink_period: got %0d expected 4", n); end
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 16; i++) init_img[i] = 8'((i % 8) + 1);
    load_card(); start();
    for (int d = 1; d <= 8; d++) begin
      run_draw(8'(d));
      checks++; if (busy_cnt != 36 || wr_cnt != 2)
        begin errors++; $display("FAIL tie_draw%0d: latency %0d writes %0d expected 36 2", d, busy_cnt, wr_cnt); end
      if (d == 7) begin
        checks++; if (endgame !== 1'b0 || game_state !== 16'h7F7F)
          begin errors++; $display("FAIL tie_before_last: endgame %b state %h expected 0 7f7f", endgame, game_state); end
      end
    end
    checks++; if (endgame !== 1'b1) begin errors++; $display("FAIL tie_endgame: got %b expected 1", endgame); end
    checks++; if (winners !== 2'b11) begin errors++; $display("FAIL tie_winners: got %b expected 11", winners); end
    checks++; if (game_state !== 16'hFFFF) begin errors++; $display("FAIL tie_game_state: got %h expected ffff", game_state); end
    for (int k = 0; k < 3; k++) begin
      guessed_number = 8'd9;
      next_edge = 1'b1; step(); next_edge = 1'b0; step();
      checks++; if (busy !== 1'b0 || endgame !== 1'b1 || winners !== 2'b11 || guessed_number_r !== 8'd8)
        begin errors++; $display("FAIL tie_hold: busy %b endgame %b winners %b guess %0d expected 0 1 11 8",
          busy, endgame, winners, guessed_number_r); end
    end
  endtask

  task automatic test_abort();
    int n;
    do_reset(); fill_seq(); load_card(); start();
    run_draw(8'd3);
    checks++; if (game_state !== 16'h0004) begin errors++; $display("FAIL abort_pre_state: got %h expected 0004", game_state); end
    guessed_number = 8'd5;
    next_edge = 1'b1; step(); next_edge = 1'b0;
    n = 0;
    while (ram_if.ram_write_en !== 1'b1 && n < 100) begin step(); n++; end
    checks++; if (n >= 100 || ram_if.ram_addr !== 4'd4)
      begin errors++; $display("FAIL abort_reach_mark: waited %0d addr %0d expected mark at 4", n, ram_if.ram_addr); end
    abort = 1'b1;
    #1;
    checks++; if (ram_if.ram_write_en !== 1'b0 || ram_if.ram_delete !== 1'b0)
      begin errors++; $display("FAIL abort_no_write: we %b del %b expected 0 0", ram_if.ram_write_en, ram_if.ram_delete); end
    step();
    abort = 1'b0;
    checks++; if (game_state !== 16'h0) begin errors++; $display("FAIL abort_game_state: got %h expected 0000", game_state); end
    checks++; if (busy !== 1'b0 || endgame !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b endgame %b expected 0 0", busy, endgame); end
    checks++; if (mem[4] !== 8'd5) begin errors++; $display("FAIL abort_ram_intact: got %0d expected 5", mem[4]); end
    next_edge = 1'b1; step(); next_edge = 1'b0; step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_ignores_draw: busy %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_scan();
    test_single_match();
    test_duplicate();
    test_zero_draw_and_blink();
    test_tie();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
